// File: rtl/input_process_pkg.sv
// Shared constants for the input_process front end: input widths, the default
// debounce length and the bit offset of the press pulses inside `button`.
package input_process_pkg;

    localparam int unsigned SW_W = 24;
    localparam int unsigned BT_W = 8;
    localparam int unsigned CH_W = SW_W + BT_W;

    // Number of consecutive differing samples before a clean output flips.
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;

    // Press pulses for bt[i] sit at button[PULSE_OFS + i].
    localparam int unsigned PULSE_OFS = 8;

endpackage : input_process_pkg

// File: rtl/input_process_debounce_bit.sv
// One debounce channel: optional 2-flop synchroniser, a run-length counter and
// the stable output q. Build option: INPUT_PROCESS_SYNC_EN adds the
// synchroniser in front of the counter (two extra cycles of latency).
module debounce_bit
    import input_process_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic raw_i,
    output logic q_o
);

    localparam int unsigned      CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             d;
    logic             q_q;
    logic             q_d;
    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

`ifdef INPUT_PROCESS_SYNC_EN
    logic [1:0] sync_q;

    // Two-flop synchroniser bringing the asynchronous pin into the clk domain.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], raw_i};
        end
    end

    assign d = sync_q[1];
`else
    assign d = raw_i;
`endif

    // Count consecutive samples that disagree with q; flip q on the last one.
    always_comb begin
        q_d   = q_q;
        cnt_d = cnt_q;
        if (d == q_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
            q_d   = d;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    // Channel state register.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_q   <= 1'b0;
            cnt_q <= '0;
        end else begin
            q_q   <= q_d;
            cnt_q <= cnt_d;
        end
    end

    assign q_o = q_q;

endmodule : debounce_bit

// File: rtl/input_process.sv
// Front-end conditioning for 24 slide switches and 8 push buttons: every raw
// bit gets its own debounce channel; buttons additionally produce one-cycle
// press pulses. Build option: INPUT_PROCESS_SYNC_EN enables the per-bit
// synchronisers inside each channel.
module input_process
    import input_process_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic                    clk,
    input  logic                    power,
    input  logic [SW_W-1:0]         sw,
    input  logic [BT_W-1:0]         bt,
    output logic [SW_W-1:0]         switch,
    output logic [PULSE_OFS+BT_W-1:0] button
);

    logic [CH_W-1:0] raw;
    logic [CH_W-1:0] clean;
    logic [BT_W-1:0] bt_clean;
    logic [BT_W-1:0] prev_q;
    logic [BT_W-1:0] pulse_q;
    logic [BT_W-1:0] pulse_d;

    assign raw = {bt, sw};

    for (genvar i = 0; i < CH_W; i++) begin : g_ch
        debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk_i   (clk),
            .rst_n_i (power),
            .raw_i   (raw[i]),
            .q_o     (clean[i])
        );
    end

    assign bt_clean = clean[CH_W-1:SW_W];

    // Rising edge of the debounced level only; releases never pulse.
    always_comb begin
        pulse_d = bt_clean & ~prev_q;
    end

    // Delay line for edge detection and the registered press pulses.
    always_ff @(posedge clk or negedge power) begin
        if (!power) begin
            prev_q  <= '0;
            pulse_q <= '0;
        end else begin
            prev_q  <= bt_clean;
            pulse_q <= pulse_d;
        end
    end

    assign switch = clean[SW_W-1:0];
    assign button = {pulse_q, bt_clean};

endmodule : input_process

// File: tb/tb_input_process.sv
// Directed bench for input_process with a short debounce length so every
// latency can be checked cycle-exactly.
module tb_input_process;

    localparam int unsigned D = 8;
`ifdef INPUT_PROCESS_SYNC_EN
    localparam int SYNC = 2;
`else
    localparam int SYNC = 0;
`endif
    // Edges after the first sampling edge k until the output changes (k+LAT).
    localparam int LAT = D - 1 + SYNC;

    logic        clk;
    logic        power;
    logic [23:0] sw;
    logic [7:0]  bt;
    logic [23:0] switch;
    logic [15:0] button;

    int n_cmp = 0;
    int n_bad = 0;

    input_process #(.DEBOUNCE_CYCLES(D)) dut (
        .clk    (clk),
        .power  (power),
        .sw     (sw),
        .bt     (bt),
        .switch (switch),
        .button (button)
    );

    // clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        // reset with all raw inputs high
        power = 1'b0;
        sw    = 24'hFFFFFF;
        bt    = 8'hFF;
        #2;
        check("rst_switch_0", 32'(switch), 32'h0);
        check("rst_button_0", 32'(button), 32'h0);
        repeat (4) step();
        check("rst_switch_1", 32'(switch), 32'h0);
        check("rst_button_1", 32'(button), 32'h0);

        // release reset with quiet inputs
        sw = '0;
        bt = '0;
        step();
        power = 1'b1;
        repeat (LAT + 4) step();
        check("idle_switch", 32'(switch), 32'h0);
        check("idle_button", 32'(button), 32'h0);

        // switch set: unchanged through LAT edges, set after the next one
        sw = 24'h100000;
        repeat (LAT) step();
        check("sw_set_early", 32'(switch), 32'h0);
        step();
        check("sw_set", 32'(switch), 32'h100000);
        repeat (3) step();
        check("sw_set_hold", 32'(switch), 32'h100000);
        check("sw_set_btn", 32'(button), 32'h0);

        // switch clear
        sw = 24'h000000;
        repeat (LAT) step();
        check("sw_clr_early", 32'(switch), 32'h100000);
        step();
        check("sw_clr", 32'(switch), 32'h0);

        // glitch one sample short of the debounce length on bt[3]
        bt = 8'h08;
        repeat (D - 1) step();
        bt = 8'h00;
        for (int i = 0; i < int'(D) + 4; i++) begin
            step();
            check("glitch_btn", 32'(button), 32'h0);
        end

        // press: level rises, pulse for exactly one cycle
        bt = 8'h01;
        repeat (LAT) step();
        check("press_early", 32'(button), 32'h0);
        step();
        check("press_level", 32'(button), 32'h0001);
        step();
        check("press_pulse", 32'(button), 32'h0101);
        step();
        check("press_pulse_end", 32'(button), 32'h0001);
        repeat (5) step();
        check("press_hold", 32'(button), 32'h0001);

        // release: level falls after the same latency, no pulse
        bt = 8'h00;
        repeat (LAT) step();
        check("rel_early", 32'(button), 32'h0001);
        step();
        check("rel_level", 32'(button), 32'h0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("rel_no_pulse", 32'(button), 32'h0);
        end

        // set sw[0] so a later reset has something visible to clear
        sw = 24'h000001;
        repeat (LAT + 1) step();
        check("sw0_set", 32'(switch), 32'h1);

        // reset mid-count of sw[5]; clear must be immediate, not on an edge
        sw = 24'h000021;
        repeat (LAT / 2) step();
        power = 1'b0;
        #1;
        check("mid_rst_async", 32'(switch), 32'h0);
        bt = 8'h02;
        repeat (2) step();
        check("mid_rst_hold", 32'(switch), 32'h0);
        check("mid_rst_btn", 32'(button), 32'h0);

        // release with sw[0], sw[5] and bt[1] already high: full latency from 0
        power = 1'b1;
        repeat (LAT) step();
        check("post_rst_sw_early", 32'(switch), 32'h0);
        check("post_rst_bt_early", 32'(button), 32'h0);
        step();
        check("post_rst_sw", 32'(switch), 32'h21);
        check("post_rst_bt", 32'(button), 32'h0002);
        step();
        check("post_rst_pulse", 32'(button), 32'h0202);
        step();
        check("post_rst_pulse_end", 32'(button), 32'h0002);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_input_process
